// File: rtl/collision_pkg.sv
// Shared constants and helpers for the snake collision checker.
// The BORDER_LOSE_EN build macro selects the playfield bound check in collision_con.
package collision_pkg;

    localparam int SEGS    = 23;
    localparam int COORD_W = 11;
    localparam int PTS_W   = 6;

    localparam logic [PTS_W-1:0]   WIN_POINTS = 6'd22;
    localparam logic [PTS_W-1:0]   POINTS_RST = 6'd1;
    localparam logic [PTS_W-1:0]   POINTS_MAX = 6'd63;

    localparam logic [COORD_W-1:0] X_MIN = 11'd16;
    localparam logic [COORD_W-1:0] X_MAX = 11'd1392;
    localparam logic [COORD_W-1:0] Y_MIN = 11'd16;
    localparam logic [COORD_W-1:0] Y_MAX = 11'd848;

    // A zero length still means the head alone is present.
    function automatic logic [PTS_W-1:0] eff_len(input logic [PTS_W-1:0] len);
        if (len == 6'd0) begin
            eff_len = 6'd1;
        end else begin
            eff_len = len;
        end
    endfunction

    function automatic logic [PTS_W-1:0] sat_inc(input logic [PTS_W-1:0] pts);
        if (pts == POINTS_MAX) begin
            sat_inc = POINTS_MAX;
        end else begin
            sat_inc = pts + 6'd1;
        end
    endfunction

endpackage

// File: rtl/collision_seg_cmp.sv
// One body segment versus the head: position equality, gated by the segment
// index lying inside the active snake length.
module collision_seg_cmp
    import collision_pkg::*;
#(
    parameter int IDX = 1
) (
    input  logic [COORD_W-1:0] seg_x,
    input  logic [COORD_W-1:0] seg_y,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic [PTS_W-1:0]   len_eff,
    output logic               hit
);

    localparam logic [PTS_W:0] IDX_V = (PTS_W+1)'(IDX);

    // Segment counts only when its index is below the active length.
    always_comb begin
        hit = 1'b0;
        if (({1'b0, len_eff} > IDX_V) && (seg_x == head_x) && (seg_y == head_y)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/collision_con.sv
// Snake game collision checker: apple/body hits, score and sticky lose/win flags.
// Build macro BORDER_LOSE_EN adds a playfield-bound check that counts as a body hit.
module collision_con
    import collision_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COORD_W-1:0]      applepos_x,
    input  logic [COORD_W-1:0]      applepos_y,
    input  logic [SEGS*COORD_W-1:0] snakepos_x,
    input  logic [SEGS*COORD_W-1:0] snakepos_y,
    input  logic [PTS_W-1:0]        length,
    input  logic [COORD_W-1:0]      curr_x,
    input  logic [COORD_W-1:0]      curr_y,
    output logic [PTS_W-1:0]        points,
    output logic                    lose,
    output logic                    win
);

    logic [COORD_W-1:0] head_x_s;
    logic [COORD_W-1:0] head_y_s;
    logic [PTS_W-1:0]   len_eff_s;
    logic [SEGS-1:1]    seg_hit_s;
    logic               border_s;
    logic               hit_body_s;
    logic               hit_apple_s;
    logic [PTS_W-1:0]   pts_inc_s;

    logic [PTS_W-1:0]   points_d, points_q;
    logic               lose_d, lose_q;
    logic               win_d, win_q;

    // Raster position is kept on the port list for drop-in compatibility only.
    logic unused_raster_s;
    assign unused_raster_s = ^{curr_x, curr_y};

    assign head_x_s  = snakepos_x[COORD_W-1:0];
    assign head_y_s  = snakepos_y[COORD_W-1:0];
    assign len_eff_s = eff_len(length);

    for (genvar g = 1; g < SEGS; g++) begin : g_seg
        collision_seg_cmp #(.IDX(g)) u_cmp (
            .seg_x   (snakepos_x[g*COORD_W +: COORD_W]),
            .seg_y   (snakepos_y[g*COORD_W +: COORD_W]),
            .head_x  (head_x_s),
            .head_y  (head_y_s),
            .len_eff (len_eff_s),
            .hit     (seg_hit_s[g])
        );
    end

    // Out-of-playfield head, when enabled, is treated like biting the body.
    always_comb begin
        border_s = 1'b0;
`ifdef BORDER_LOSE_EN
        if ((head_x_s < X_MIN) || (head_x_s > X_MAX) ||
            (head_y_s < Y_MIN) || (head_y_s > Y_MAX)) begin
            border_s = 1'b1;
        end else begin
            border_s = 1'b0;
        end
`endif
    end

    assign hit_body_s  = (|seg_hit_s) | border_s;
    assign hit_apple_s = (head_x_s == applepos_x) && (head_y_s == applepos_y);
    assign pts_inc_s   = sat_inc(points_q);

    // Next score/flags; the points<=length guard absorbs the top level's one-tick lag.
    always_comb begin
        points_d = points_q;
        lose_d   = lose_q;
        win_d    = win_q;
        if (lose_q || win_q) begin
            points_d = points_q;
        end else if (hit_body_s) begin
            lose_d = 1'b1;
        end else if (hit_apple_s && (points_q <= len_eff_s)) begin
            points_d = pts_inc_s;
            if (pts_inc_s >= WIN_POINTS) begin
                win_d = 1'b1;
            end else begin
                win_d = 1'b0;
            end
        end else begin
            points_d = points_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            points_q <= POINTS_RST;
            lose_q   <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            points_q <= points_d;
            lose_q   <= lose_d;
            win_q    <= win_d;
        end
    end

    assign points = points_q;
    assign lose   = lose_q;
    assign win    = win_q;

endmodule

// File: tb/tb_collision_con.sv
// Scoreboard bench for collision_con: integer reference model of the game rules,
// expected outputs queued at stimulus time and compared by a separate monitor.
module tb_collision_con;
    import collision_pkg::*;

    logic                    clk;
    logic                    rst;
    logic [COORD_W-1:0]      applepos_x, applepos_y;
    logic [SEGS*COORD_W-1:0] snakepos_x, snakepos_y;
    logic [PTS_W-1:0]        length;
    logic [COORD_W-1:0]      curr_x, curr_y;
    logic [PTS_W-1:0]        points;
    logic                    lose, win;

    collision_con dut (
        .clk        (clk),
        .rst        (rst),
        .applepos_x (applepos_x),
        .applepos_y (applepos_y),
        .snakepos_x (snakepos_x),
        .snakepos_y (snakepos_y),
        .length     (length),
        .curr_x     (curr_x),
        .curr_y     (curr_y),
        .points     (points),
        .lose       (lose),
        .win        (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    pts;
        bit    lose;
        bit    win;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int sx[SEGS];
    int sy[SEGS];
    int ax, ay, len;
    int m_pts = 1;
    bit m_lose = 0;
    bit m_win = 0;

    // Game rules stated directly in integer arithmetic on the segment arrays.
    task automatic model_step(input bit r);
        int  le;
        bit  body;
        bit  apple;
        if (!r) begin
            m_pts = 1; m_lose = 0; m_win = 0;
        end else if (!(m_lose || m_win)) begin
            le = (len == 0) ? 1 : len;
            body = 0;
            for (int i = 1; i < SEGS; i++)
                if (i < le && sx[i] == sx[0] && sy[i] == sy[0]) body = 1;
`ifdef BORDER_LOSE_EN
            if (sx[0] < 16 || sx[0] > 1392 || sy[0] < 16 || sy[0] > 848) body = 1;
`endif
            apple = (sx[0] == ax) && (sy[0] == ay);
            if (body) m_lose = 1;
            else if (apple && m_pts <= le) begin
                m_pts = (m_pts >= 63) ? 63 : m_pts + 1;
                if (m_pts >= 22) m_win = 1;
            end
        end
    endtask

    // Drive one tick of stimulus and queue the expected post-edge outputs.
    task automatic tick(input bit r, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        applepos_x = COORD_W'(ax);
        applepos_y = COORD_W'(ay);
        length = PTS_W'(len);
        curr_x = COORD_W'($urandom_range(0, 2047));
        curr_y = COORD_W'($urandom_range(0, 2047));
        for (int i = 0; i < SEGS; i++) begin
            snakepos_x[i*COORD_W +: COORD_W] = COORD_W'(sx[i]);
            snakepos_y[i*COORD_W +: COORD_W] = COORD_W'(sy[i]);
        end
        model_step(r);
        e.pts = m_pts; e.lose = m_lose; e.win = m_win; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic park_body();
        for (int i = 1; i < SEGS; i++) begin
            sx[i] = 1200;
            sy[i] = 16 + 32 * i;
        end
    endtask

    task automatic set_head(input int x, input int y);
        sx[0] = x; sy[0] = y;
    endtask

    // Monitor: outputs are valid every tick, so one expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (points !== PTS_W'(e.pts) || lose !== e.lose || win !== e.win) begin
                    n_bad++;
                    $display("FAIL %s: got points=%0d lose=%b win=%b, expected points=%0d lose=%b win=%b",
                             e.tag, points, lose, win, e.pts, e.lose, e.win);
                end
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b0;
        park_body();
        ax = 656; ay = 498; len = 1;

        // 1: reset then idle
        set_head(784, 464);
        tick(0, "reset");
        tick(1, "idle_after_reset");

        // 2: apple with length 1, then lagging length must not double count
        set_head(656, 498);
        tick(1, "apple_len1");
        for (int k = 0; k < 3; k++) tick(1, "apple_guard_hold");

        // 3: body hit at segment 3, later apples ignored
        tick(0, "reset3");
        len = 5;
        set_head(400, 400); sx[3] = 400; sy[3] = 400;
        ax = 100; ay = 100;
        tick(1, "body_hit_seg3");
        park_body();
        ax = 400; ay = 400;
        tick(1, "frozen_after_lose");
        tick(1, "frozen_after_lose2");

        // 4: matching segment beyond the active length
        tick(0, "reset4");
        sx[6] = 400; sy[6] = 400; ax = 100; ay = 100;
        tick(1, "seg6_beyond_len");
        sx[5] = 400; sy[5] = 400;
        tick(1, "seg5_at_len_edge");
        park_body();

        // 5: climb to the win score, then reset clears it
        tick(0, "reset5");
        len = 21; set_head(656, 498); ax = 656; ay = 498;
        for (int k = 0; k < 21; k++) tick(1, "climb_to_win");
        tick(1, "frozen_after_win");
        tick(0, "reset_after_win");

        // 6: head outside the playfield
        tick(1, "idle6");
        set_head(1424, 464); ax = 656; ay = 498; len = 3;
        tick(1, "border_head");
        tick(0, "reset6");

        // Random play on a coarse grid so apples and bites happen often.
        for (int n = 0; n < 400; n++) begin
            len = $urandom_range(1, SEGS);
            for (int i = 0; i < SEGS; i++) begin
                sx[i] = 16 + 32 * $urandom_range(0, 5);
                sy[i] = 16 + 32 * $urandom_range(0, 5);
            end
            if ($urandom_range(0, 9) == 0) sx[0] = $urandom_range(0, 2047);
            if ($urandom_range(0, 1) == 0) begin
                ax = sx[0]; ay = sy[0];
            end else begin
                ax = 16 + 32 * $urandom_range(0, 5);
                ay = 16 + 32 * $urandom_range(0, 5);
            end
            tick($urandom_range(0, 24) != 0, "random");
        end

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
